sys_ctrl_rx_cmd: RTL

//  Command sequencer between UART_RX_TOP, the register file, the ALU and the UART TX path.
//  It collects byte frames from the RX data_valid/P_DATA stream and decodes the command byte.
//  It then performs the register-file write or read, or the ALU operation.

---
 rtl/sys_ctrl_rx_cmd.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_rx_cmd.sv
// sys_ctrl_rx_cmd: UART command sequencer driving RF writes/reads and ALU ops, returning results over TX
module sys_ctrl_rx_cmd #(
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] CMD_WR      = 8'hAA,
    parameter logic [7:0] CMD_RD      = 8'hBB,
    parameter logic [7:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [7:0] CMD_ALU_NOP = 8'hDD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_D_VLD,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_ERR,
    output logic              RF_WR_EN,
    output logic              RF_RD_EN,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic [7:0]        RF_WR_DATA,
    input  logic [7:0]        RF_RD_DATA,
    input  logic              RF_RD_VLD,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    input  logic [15:0]       ALU_OUT,
    input  logic              ALU_OUT_VLD,
    output logic              CLK_GATE_EN,
    output logic [7:0]        TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              BUSY
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_REQ, TX_HI, TX_LO
    } state_t;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              alu_en_q, alu_en_d;
    logic              start_q, start_d;
    logic [3:0]        fun_q, fun_d;
    logic              gate_q, gate_d;
    logic [15:0]       buf_q, buf_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_vld_q, tx_vld_d;
    logic              collect;

    assign collect     = state_q inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN};
    assign BUSY        = !collect;
    assign RF_WR_EN    = wr_en_q;
    assign RF_RD_EN    = rd_en_q;
    assign RF_ADDR     = addr_q;
    assign RF_WR_DATA  = wdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = fun_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;

    // Next-state and strobe decode; an RX error during frame collection wins over any byte
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        start_d   = start_q;
        fun_d     = fun_q;
        gate_d    = gate_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        if (collect && RX_ERR) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (RX_D_VLD)
                    state_d = RX_P_DATA == CMD_WR      ? WR_ADDR :
                              RX_P_DATA == CMD_RD      ? RD_ADDR :
                              RX_P_DATA == CMD_ALU_OP  ? OP_A    :
                              RX_P_DATA == CMD_ALU_NOP ? FUN     : IDLE;
                WR_ADDR: if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
                WR_DATA: if (RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    wdata_d = RX_P_DATA;
                    state_d = IDLE;
                end
                RD_ADDR: if (RX_D_VLD) begin
                    rd_en_d = 1'b1;
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = RD_WAIT;
                end
                RD_WAIT: if (RF_RD_VLD) begin
                    buf_d   = {8'h00, RF_RD_DATA};
                    cnt_d   = 2'd1;
                    state_d = TX_REQ;
                end
                OP_A: if (RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = RX_P_DATA;
                    state_d = OP_B;
                end
                OP_B: if (RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_W'(1);
                    wdata_d = RX_P_DATA;
                    state_d = FUN;
                end
                FUN: if (RX_D_VLD) begin
                    gate_d  = 1'b1;
                    start_d = 1'b1;
                    fun_d   = RX_P_DATA[3:0];
                    state_d = ALU_WAIT;
                end
                ALU_WAIT: if (start_q) begin
                    alu_en_d = 1'b1;
                    start_d  = 1'b0;
                end else if (ALU_OUT_VLD) begin
                    buf_d   = ALU_OUT;
                    cnt_d   = 2'd2;
                    gate_d  = 1'b0;
                    state_d = TX_REQ;
                end
                TX_REQ: if (!TX_BUSY) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = buf_q[7:0];
                    buf_d     = {8'h00, buf_q[15:8]};
                    cnt_d     = cnt_q - 2'd1;
                    state_d   = TX_HI;
                end
                TX_HI: if (TX_BUSY) state_d = TX_LO;
                TX_LO: if (!TX_BUSY) state_d = cnt_q != 2'd0 ? TX_REQ : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, all cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            alu_en_q  <= 1'b0;
            start_q   <= 1'b0;
            fun_q     <= '0;
            gate_q    <= 1'b0;
            buf_q     <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            alu_en_q  <= alu_en_d;
            start_q   <= start_d;
            fun_q     <= fun_d;
            gate_q    <= gate_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end
endmodule
